turn_controller: RTL
====================

# turn_controller

Parametrised game-flow controller for N-player turn-based board games: it sequences turns, runs a built-in per-turn countdown, forces a random move on timeout, handshakes with external move-validation and win-check units, detects ties by move count, and keeps per-player scores across games. It sits between the input/timer front end and the board, validator, win-checker and display blocks of the game top level.

## Interface
- N_PLAYERS, 2, number of players (≥2); PW = max(1, $clog2(N_PLAYERS))
- TURN_CYCLES, 250, clock cycles allowed per turn (≥2); TW = $clog2(TURN_CYCLES)
- MAX_MOVES, 9, moves before the board is full; MW = $clog2(MAX_MOVES+1)
- SCORE_W, 4, width of each score counter
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin game; sampled only in IDLE and DONE
- move_ready  in  1  current player has submitted a move
- validate_done  in  1  validator result available this cycle
- move_valid  in  1  validator verdict, qualified by validate_done
- check_done  in  1  win-check result available this cycle
- win  in  1  current player has won, qualified by check_done
- player  out  PW  index of player whose turn it is
- time_left  out  TW  remaining cycles of the current turn
- timer_en  out  1  high while in WAIT_MOVE
- play_random  out  1  one-cycle request to the random-move engine
- validate_req  out  1  held high in VALIDATE
- check_req  out  1  held high in CHECK
- print_move  out  1  one-cycle pulse after a move is committed
- game_over  out  1  high in DONE
- tie  out  1  game ended with no winner; valid while game_over
- winner  out  PW  winning player; valid while game_over and !tie
- moves  out  MW  moves committed in the current game
- scores  out  N_PLAYERS*SCORE_W  player k's score at bits [k*SCORE_W +: SCORE_W]

## Operation
- States: IDLE, WAIT_MOVE, RANDOM, VALIDATE, CHECK, NEXT, DONE. Moore outputs timer_en, play_random, validate_req, check_req, and game_over are decoded from the registered state.
- IDLE: on start, go to WAIT_MOVE. Set player to first_player, clear moves, load the timer with TURN_CYCLES-1.
- WAIT_MOVE: the timer decrements each cycle.
  - move_ready high: go to VALIDATE. This takes priority over timeout in the same cycle.
  - Timer at 0 with move_ready low: go to RANDOM.
- RANDOM: one cycle. The random engine only produces legal moves, so the move is committed directly: moves+1, print_move, then CHECK.
- VALIDATE: wait indefinitely for validate_done.
  - move_valid=1: commit the move (moves+1, print_move), then go to CHECK.
  - move_valid=0: return to WAIT_MOVE. The timer is not reloaded; the remaining time continues.
- CHECK: wait for check_done.
  - win=1: go to DONE with winner=player, tie=0. scores[player] increments, saturating at all-ones.
  - Else if moves==MAX_MOVES: go to DONE with tie=1. Scores are unchanged.
  - Else: go to NEXT.
- NEXT: one cycle. player = (player+1) mod N_PLAYERS, wrapping from N_PLAYERS-1 to 0. Reload the timer, then go to WAIT_MOVE.
- DONE: hold game_over, tie, winner, moves, and scores.
  - On start: first_player = (first_player+1) mod N_PLAYERS, then perform the same actions as a start from IDLE.
- start is ignored in all states except IDLE and DONE.
- Scores persist across games and are cleared only by rst.
- rst at any time, including mid-turn or mid-handshake:
  - State goes to IDLE.
  - player, first_player, moves, time_left, winner, tie, and all scores go to 0.
  - All request and strobe outputs go to 0.

## Timing
- start to WAIT_MOVE: 1 cycle. time_left reads TURN_CYCLES-1 on the first WAIT_MOVE cycle.
- An unanswered turn spends exactly TURN_CYCLES cycles in WAIT_MOVE; RANDOM is entered on the following edge.
- print_move is registered: it is high for exactly the one cycle after the commit edge (after validate_done·move_valid, or after RANDOM).
- moves updates on the same edge as the commit.
- validate_req and check_req fall on the edge that samples the corresponding done signal.
- Done signals are ignored outside their own state.
- Fastest turn with no win: WAIT_MOVE(1) → VALIDATE(1, done same cycle) → CHECK(1) → NEXT(1), giving 4 cycles.

## Test plan
- N=2, TURN_CYCLES=4: start, with no move_ready for 4 WAIT_MOVE cycles → RANDOM on cycle 5, play_random for 1 cycle, moves=1, print_move pulse. With check_done·!win, player becomes 1 and time_left=3.
- move_ready, then validate_done with move_valid=0 after time_left reaches 1 → back to WAIT_MOVE with time_left continuing from 1. moves is unchanged and there is no print_move.
- Same cycle: move_ready=1 and time_left=0 → VALIDATE is taken, not RANDOM.
- MAX_MOVES=9, all moves valid, never win → after the 9th CHECK: game_over=1, tie=1, scores unchanged.
- N=3: player 2 wins → winner=2, scores[2]=1. Restart with start → player starts at 1 (first_player rotated) and moves=0. Repeat wins with SCORE_W=2 until the score saturates at 3.
- Assert rst while in VALIDATE with validate_req high → all outputs go to their reset values immediately; start after release begins with player 0.

Source files
------------

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencing, per-turn countdown, validate/win-check handshakes and score keeping
module turn_controller #(
    parameter int N_PLAYERS   = 2,
    parameter int TURN_CYCLES = 250,
    parameter int MAX_MOVES   = 9,
    parameter int SCORE_W     = 4,
    localparam int PW = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1,
    localparam int TW = $clog2(TURN_CYCLES),
    localparam int MW = $clog2(MAX_MOVES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         move_ready,
    input  logic                         validate_done,
    input  logic                         move_valid,
    input  logic                         check_done,
    input  logic                         win,
    output logic [PW-1:0]                player,
    output logic [TW-1:0]                time_left,
    output logic                         timer_en,
    output logic                         play_random,
    output logic                         validate_req,
    output logic                         check_req,
    output logic                         print_move,
    output logic                         game_over,
    output logic                         tie,
    output logic [PW-1:0]                winner,
    output logic [MW-1:0]                moves,
    output logic [N_PLAYERS*SCORE_W-1:0] scores
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_RANDOM,
        S_VALIDATE,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [PW-1:0]                player_q;
    logic [PW-1:0]                first_q;
    logic [PW-1:0]                first_sel;
    logic [TW-1:0]                time_q;
    logic [MW-1:0]                moves_q;
    logic                         print_q;
    logic                         tie_q;
    logic [PW-1:0]                winner_q;
    logic [N_PLAYERS*SCORE_W-1:0] scores_q;
    logic                         start_game;
    logic                         commit;
    logic                         check_hit;
    logic                         board_full;

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        return (p == PW'(N_PLAYERS - 1)) ? '0 : p + PW'(1);
    endfunction

    // start only counts while no game is running
    assign start_game = start && (state_q == S_IDLE || state_q == S_DONE);
    // a random move is legal by construction, a submitted one only once validated
    assign commit     = (state_q == S_RANDOM) ||
                        (state_q == S_VALIDATE && validate_done && move_valid);
    assign check_hit  = (state_q == S_CHECK) && check_done;
    assign board_full = (moves_q == MW'(MAX_MOVES));
    // a restart from DONE hands the opening move to the next player
    assign first_sel  = (state_q == S_DONE) ? next_player(first_q) : first_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic; move_ready wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WAIT_MOVE;
            S_WAIT_MOVE: begin
                if (move_ready)          state_d = S_VALIDATE;
                else if (time_q == '0)   state_d = S_RANDOM;
            end
            S_RANDOM:   state_d = S_CHECK;
            S_VALIDATE: if (validate_done) state_d = move_valid ? S_CHECK : S_WAIT_MOVE;
            S_CHECK:    if (check_done) state_d = (win || board_full) ? S_DONE : S_NEXT;
            S_NEXT:     state_d = S_WAIT_MOVE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        timer_en     = 1'b0;
        play_random  = 1'b0;
        validate_req = 1'b0;
        check_req    = 1'b0;
        game_over    = 1'b0;
        case (state_q)
            S_WAIT_MOVE: timer_en     = 1'b1;
            S_RANDOM:    play_random  = 1'b1;
            S_VALIDATE:  validate_req = 1'b1;
            S_CHECK:     check_req    = 1'b1;
            S_DONE:      game_over    = 1'b1;
            default:     ;
        endcase
    end

    // current and opening player
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_q <= '0;
            first_q  <= '0;
        end else if (start_game) begin
            first_q  <= first_sel;
            player_q <= first_sel;
        end else if (state_q == S_NEXT) begin
            player_q <= next_player(player_q);
        end
    end

    // turn countdown; frozen outside WAIT_MOVE so a rejected move keeps its remaining time
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            time_q <= '0;
        else if (start_game || state_q == S_NEXT)
            time_q <= TW'(TURN_CYCLES - 1);
        else if (state_q == S_WAIT_MOVE && time_q != '0)
            time_q <= time_q - TW'(1);
    end

    // move counter and the registered commit strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            moves_q <= '0;
            print_q <= 1'b0;
        end else begin
            print_q <= commit;
            if (start_game)  moves_q <= '0;
            else if (commit) moves_q <= moves_q + MW'(1);
        end
    end

    // game result, captured when the win check answers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q <= '0;
            tie_q    <= 1'b0;
        end else if (start_game) begin
            winner_q <= '0;
            tie_q    <= 1'b0;
        end else if (check_hit) begin
            if (win) begin
                winner_q <= player_q;
                tie_q    <= 1'b0;
            end else if (board_full) begin
                tie_q    <= 1'b1;
            end
        end
    end

    // per-player saturating scores, kept across games
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scores_q <= '0;
        end else if (check_hit && win) begin
            for (int k = 0; k < N_PLAYERS; k++) begin
                if (PW'(k) == player_q && scores_q[k*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}})
                    scores_q[k*SCORE_W +: SCORE_W] <= scores_q[k*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
        end
    end

    assign player     = player_q;
    assign time_left  = time_q;
    assign print_move = print_q;
    assign tie        = tie_q;
    assign winner     = winner_q;
    assign moves      = moves_q;
    assign scores     = scores_q;

endmodule
